// File: rtl/tm_pkg.sv
// Shared types for the search time manager.
// Contents: mode and FSM state enums, default ms width and the ms_t alias.
package tm_pkg;
  localparam int TM_TIME_W = 32;

  typedef logic [TM_TIME_W-1:0] ms_t;

  typedef enum logic [1:0] {
    CLOCK    = 2'd0,
    MOVETIME = 2'd1,
    INFINITE = 2'd2,
    PONDER   = 2'd3
  } tm_mode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_DIV,
    S_CLAMP,
    S_RUN,
    S_HOLD,
    S_INF
  } tm_state_t;
endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, W cycles per divide.
// Ports:
//   clk_in, rst_n_in        clock, async active-low reset
//   start_in                load operands and begin (restarts a divide in flight)
//   dividend_in, divisor_in operands, sampled on start_in
//   busy_out                divide in progress
//   done_out                one-cycle pulse, quotient_out valid from this cycle
//   quotient_out            result, held until the next start
module seq_divider #(
  parameter int W = 32
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  input  logic         start_in,
  input  logic [W-1:0] dividend_in,
  input  logic [W-1:0] divisor_in,
  output logic         busy_out,
  output logic         done_out,
  output logic [W-1:0] quotient_out
);
  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic [W-1:0]  r_rem, r_quo, r_dvs;
  logic [CW-1:0] r_cnt;
  logic          r_busy, r_done;

  // The first bit is resolved in the start cycle straight from the inputs,
  // so W bits finish W cycles after start.
  logic [W-1:0] w_rem_in, w_quo_in, w_dvs;
  logic [W:0]   w_shift, w_diff;
  logic         w_ge;
  assign w_rem_in = start_in ? '0 : r_rem;
  assign w_quo_in = start_in ? dividend_in : r_quo;
  assign w_dvs    = start_in ? divisor_in : r_dvs;
  assign w_shift  = {w_rem_in, w_quo_in[W-1]};
  assign w_diff   = w_shift - {1'b0, w_dvs};
  // Remainder stays below the divisor, so the diff sign bit is exact.
  assign w_ge     = ~w_diff[W];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start_in || r_busy) begin
        r_rem <= w_ge ? w_diff[W-1:0] : w_shift[W-1:0];
        r_quo <= {w_quo_in[W-2:0], w_ge};
        if (start_in) begin
          r_dvs  <= divisor_in;
          r_cnt  <= CW'(1);
          r_busy <= 1'b1;
        end else if (r_cnt == LAST) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign busy_out     = r_busy;
  assign done_out     = r_done;
  assign quotient_out = r_quo;
endmodule

// File: rtl/search_time_manager.sv
// Per-search ms budget: computes a budget from UCI go fields, counts it down
// and pulses stop_out when the search must end.
// Ports:
//   clk_in, rst_n_in               clock, async active-low reset
//   go_in, stop_in, ponderhit_in   one-cycle UCI command pulses
//   mode_in, side_in               search mode, side to move (latched on go)
//   wtime/btime/winc/binc_in       signed ms clocks and increments
//   movestogo_in, movetime_in      moves to next control (0 = sudden death), fixed ms
//   busy_out, running_out          search active, ms countdown active
//   budget_ms_out, time_ms_out     computed budget, remaining ms
//   elapsed_ms_out                 ms since countdown start (saturating)
//   stop_out                       one-cycle pulse: end the search
module search_time_manager
  import tm_pkg::*;
#(
  parameter int CLOCK_FREQ   = 50_000_000,
  parameter int TIME_W       = TM_TIME_W,
  parameter int BUDGET_SHIFT = 3,
  parameter int OVERHEAD_MS  = 20,
  parameter int MIN_MS       = 1
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              go_in,
  input  logic              stop_in,
  input  logic              ponderhit_in,
  input  logic [1:0]        mode_in,
  input  logic              side_in,
  input  logic [TIME_W-1:0] wtime_in,
  input  logic [TIME_W-1:0] btime_in,
  input  logic [TIME_W-1:0] winc_in,
  input  logic [TIME_W-1:0] binc_in,
  input  logic [7:0]        movestogo_in,
  input  logic [TIME_W-1:0] movetime_in,
  output logic              busy_out,
  output logic              running_out,
  output logic [TIME_W-1:0] budget_ms_out,
  output logic [TIME_W-1:0] time_ms_out,
  output logic [TIME_W-1:0] elapsed_ms_out,
  output logic              stop_out
);
  localparam int CYC_PER_MS = CLOCK_FREQ / 1000;
  localparam int PW = (CYC_PER_MS > 1) ? $clog2(CYC_PER_MS) : 1;
  localparam logic [PW-1:0]     PRESC_LAST = PW'(CYC_PER_MS - 1);
  localparam logic [TIME_W-1:0] OVH  = TIME_W'(OVERHEAD_MS);
  localparam logic [TIME_W-1:0] MINV = TIME_W'(MIN_MS);
  localparam logic [TIME_W-1:0] ONE  = TIME_W'(1);

  tm_state_t         r_state;
  tm_mode_t          r_mode;
  logic              r_side;
  logic [TIME_W-1:0] r_wtime, r_btime, r_winc, r_binc, r_movetime;
  logic [7:0]        r_mtg;
  logic [TIME_W-1:0] r_time, r_inc, r_base;
  logic [PW-1:0]     r_presc;
  logic [TIME_W-1:0] r_budget, r_time_ms, r_elapsed;
  logic              r_running, r_stop;

  // Own clock and increment, negatives floored to zero.
  logic [TIME_W-1:0] w_own_time, w_own_inc, w_time_sel, w_inc_sel;
  assign w_own_time = r_side ? r_btime : r_wtime;
  assign w_own_inc  = r_side ? r_binc  : r_winc;
  assign w_time_sel = w_own_time[TIME_W-1] ? '0 : w_own_time;
  assign w_inc_sel  = w_own_inc[TIME_W-1]  ? '0 : w_own_inc;

  logic w_need_div;
  assign w_need_div = ((r_mode == CLOCK) || (r_mode == PONDER)) && (r_mtg != 8'd0);

  logic              w_div_start, w_div_busy, w_div_done;
  logic [TIME_W-1:0] w_quo;
  assign w_div_start = (r_state == S_SELECT) && w_need_div;

  seq_divider #(.W(TIME_W)) u_div (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .start_in    (w_div_start),
    .dividend_in (w_time_sel),
    .divisor_in  ({{(TIME_W-8){1'b0}}, r_mtg}),
    .busy_out    (w_div_busy),
    .done_out    (w_div_done),
    .quotient_out(w_quo)
  );

  // Clock-mode budget: base + inc (saturating), capped by own clock minus
  // the safety margin, floored at MIN_MS.
  logic [TIME_W:0]   w_sum;
  logic [TIME_W-1:0] w_sat, w_cap, w_lim, w_clk_budget, w_mt_budget;
  assign w_sum        = {1'b0, r_base} + {1'b0, r_inc};
  assign w_sat        = w_sum[TIME_W] ? '1 : w_sum[TIME_W-1:0];
  assign w_cap        = (r_time > OVH) ? (r_time - OVH) : '0;
  assign w_lim        = (w_sat < w_cap) ? w_sat : w_cap;
  assign w_clk_budget = (w_lim < MINV) ? MINV : w_lim;
  assign w_mt_budget  = (r_movetime < MINV) ? MINV : r_movetime;

  logic              w_wrap;
  logic [TIME_W-1:0] w_elapsed_nx;
  assign w_wrap       = (r_presc == PRESC_LAST);
  assign w_elapsed_nx = (&r_elapsed) ? r_elapsed : (r_elapsed + ONE);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state    <= S_IDLE;
      r_mode     <= CLOCK;
      r_side     <= 1'b0;
      r_wtime    <= '0;
      r_btime    <= '0;
      r_winc     <= '0;
      r_binc     <= '0;
      r_movetime <= '0;
      r_mtg      <= '0;
      r_time     <= '0;
      r_inc      <= '0;
      r_base     <= '0;
      r_presc    <= '0;
      r_budget   <= '0;
      r_time_ms  <= '0;
      r_elapsed  <= '0;
      r_running  <= 1'b0;
      r_stop     <= 1'b0;
    end else begin
      r_stop <= 1'b0;
      if (go_in) begin
        // A new go silently replaces any search in flight.
        r_mode     <= tm_mode_t'(mode_in);
        r_side     <= side_in;
        r_wtime    <= wtime_in;
        r_btime    <= btime_in;
        r_winc     <= winc_in;
        r_binc     <= binc_in;
        r_movetime <= movetime_in;
        r_mtg      <= movestogo_in;
        r_running  <= 1'b0;
        r_state    <= S_SELECT;
      end else if (stop_in && (r_state != S_IDLE)) begin
        r_stop    <= 1'b1;
        r_running <= 1'b0;
        r_state   <= S_IDLE;
      end else begin
        case (r_state)
          S_SELECT: begin
            r_time  <= w_time_sel;
            r_inc   <= w_inc_sel;
            r_base  <= w_time_sel >> BUDGET_SHIFT;
            r_state <= w_need_div ? S_DIV : S_CLAMP;
          end
          S_DIV: begin
            if (w_div_done) begin
              r_base  <= w_quo;
              r_state <= S_CLAMP;
            end else if (!w_div_busy) begin
              r_state <= S_SELECT;  // divider lost its job: reissue
            end
          end
          S_CLAMP: begin
            r_presc   <= '0;
            r_elapsed <= '0;
            case (r_mode)
              MOVETIME: begin
                r_budget  <= w_mt_budget;
                r_time_ms <= w_mt_budget;
                r_running <= 1'b1;
                r_state   <= S_RUN;
              end
              PONDER: begin
                r_budget  <= w_clk_budget;
                r_time_ms <= w_clk_budget;
                r_state   <= S_HOLD;
              end
              INFINITE: begin
                r_budget  <= '1;
                r_time_ms <= '1;
                r_state   <= S_INF;
              end
              default: begin
                r_budget  <= w_clk_budget;
                r_time_ms <= w_clk_budget;
                r_running <= 1'b1;
                r_state   <= S_RUN;
              end
            endcase
          end
          S_RUN: begin
            if (w_wrap) begin
              r_presc   <= '0;
              r_time_ms <= r_time_ms - ONE;
              r_elapsed <= w_elapsed_nx;
              if (r_time_ms == ONE) begin
                r_stop    <= 1'b1;
                r_running <= 1'b0;
                r_state   <= S_IDLE;
              end
            end else begin
              r_presc <= r_presc + PW'(1);
            end
          end
          S_HOLD: begin
            if (ponderhit_in) begin
              r_presc   <= '0;
              r_running <= 1'b1;
              r_state   <= S_RUN;
            end
          end
          S_INF: begin
            if (w_wrap) begin
              r_presc   <= '0;
              r_elapsed <= w_elapsed_nx;
            end else begin
              r_presc <= r_presc + PW'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy_out       = (r_state != S_IDLE);
  assign running_out    = r_running;
  assign budget_ms_out  = r_budget;
  assign time_ms_out    = r_time_ms;
  assign elapsed_ms_out = r_elapsed;
  assign stop_out       = r_stop;
endmodule

// File: tb/tb_search_time_manager.sv
// Scoreboard bench for search_time_manager at 10 clock cycles per ms.
// Stimulus pushes expected running/stop events; the monitor pops them as the
// DUT raises running_out or pulses stop_out. Cycle distances are counted in
// clock edges between the edge that sampled the reference event and the edge
// that produced the output.
module tb_search_time_manager;
  logic        clk_in = 1'b0;
  logic        rst_n_in, go_in, stop_in, ponderhit_in, side_in;
  logic [1:0]  mode_in;
  logic [31:0] wtime_in, btime_in, winc_in, binc_in, movetime_in;
  logic [7:0]  movestogo_in;
  logic        busy_out, running_out, stop_out;
  logic [31:0] budget_ms_out, time_ms_out, elapsed_ms_out;

  search_time_manager #(.CLOCK_FREQ(10_000)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .go_in(go_in), .stop_in(stop_in),
    .ponderhit_in(ponderhit_in), .mode_in(mode_in), .side_in(side_in),
    .wtime_in(wtime_in), .btime_in(btime_in), .winc_in(winc_in), .binc_in(binc_in),
    .movestogo_in(movestogo_in), .movetime_in(movetime_in),
    .busy_out(busy_out), .running_out(running_out), .budget_ms_out(budget_ms_out),
    .time_ms_out(time_ms_out), .elapsed_ms_out(elapsed_ms_out), .stop_out(stop_out)
  );

  always #5 clk_in = ~clk_in;

  localparam int EV_RUN  = 0;
  localparam int EV_STOP = 1;

  typedef struct {
    int          kind;
    logic [31:0] budget;
    int          cycles;
    bit          use_mark;  // distance from mark_cyc instead of go/run edge
  } exp_t;

  exp_t q[$];
  int   checks = 0, failures = 0;
  int   cyc = 0, go_cyc = 0, run_cyc = 0, mark_cyc = 0;
  logic prev_run = 1'b0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [31:0] budget, input int cycles, input bit use_mark);
    exp_t e;
    e.kind = kind; e.budget = budget; e.cycles = cycles; e.use_mark = use_mark;
    q.push_back(e);
  endtask

  task automatic take(input int kind);
    exp_t e;
    int   rf;
    if (q.size() == 0) begin
      checks++; failures++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d expected none", kind, cyc);
    end else begin
      e = q.pop_front();
      chk("event_kind", 64'(kind), 64'(e.kind));
      rf = e.use_mark ? mark_cyc : ((kind == EV_RUN) ? go_cyc : run_cyc);
      if (kind == EV_RUN) begin
        chk("run_latency", 64'(cyc - rf), 64'(e.cycles));
        chk("budget", 64'(budget_ms_out), 64'(e.budget));
      end else begin
        chk("stop_latency", 64'(cyc - rf), 64'(e.cycles));
      end
    end
  endtask

  always @(negedge clk_in) begin
    if (rst_n_in) begin
      if (running_out && !prev_run) begin
        run_cyc = cyc;
        take(EV_RUN);
      end
      if (stop_out) take(EV_STOP);
    end
    prev_run <= running_out;
  end

  task automatic do_go(input logic [1:0] m, input logic s, input logic [31:0] wt, bt, wi, bi,
                       input logic [7:0] mtg, input logic [31:0] mt);
    mode_in = m; side_in = s; wtime_in = wt; btime_in = bt; winc_in = wi; binc_in = bi;
    movestogo_in = mtg; movetime_in = mt; go_in = 1'b1;
    @(posedge clk_in); #1;
    go_cyc = cyc; go_in = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_in = 1'b1;
    @(posedge clk_in); #1;
    mark_cyc = cyc; stop_in = 1'b0;
  endtask

  task automatic pulse_ph();
    ponderhit_in = 1'b1;
    @(posedge clk_in); #1;
    mark_cyc = cyc; ponderhit_in = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string nm);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(posedge clk_in); n++;
    end
    @(negedge clk_in); #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL timeout_%s: got %0d pending events expected 0", nm, q.size());
      q.delete();
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"}, 64'(busy_out), 64'd0);
    chk({nm, "_running"}, 64'(running_out), 64'd0);
    chk({nm, "_budget"}, 64'(budget_ms_out), 64'd0);
    chk({nm, "_time"}, 64'(time_ms_out), 64'd0);
    chk({nm, "_elapsed"}, 64'(elapsed_ms_out), 64'd0);
    chk({nm, "_stop"}, 64'(stop_out), 64'd0);
  endtask

  initial begin
    rst_n_in = 1'b0; go_in = 1'b0; stop_in = 1'b0; ponderhit_in = 1'b0;
    mode_in = 2'd0; side_in = 1'b0; wtime_in = '0; btime_in = '0;
    winc_in = '0; binc_in = '0; movestogo_in = '0; movetime_in = '0;
    repeat (3) @(posedge clk_in); #1;
    chk_zero("reset");
    rst_n_in = 1'b1;
    repeat (2) @(posedge clk_in); #1;

    // stop in IDLE must not pulse (monitor flags any stop)
    pulse_stop();
    repeat (3) @(posedge clk_in); #1;
    chk("idle_stop_busy", 64'(busy_out), 64'd0);

    // CLOCK white, 8000/100 sudden death: 1000 + 100
    push(EV_RUN, 32'd1100, 2, 1'b0);
    push(EV_STOP, 32'd0, 11000, 1'b0);
    do_go(2'd0, 1'b0, 32'd8000, 32'd0, 32'd100, 32'd0, 8'd0, 32'd0);
    wait_drain(11100, "clock8000");
    chk("c1_busy_after", 64'(busy_out), 64'd0);
    chk("c1_time_after", 64'(time_ms_out), 64'd0);
    chk("c1_budget_hold", 64'(budget_ms_out), 64'd1100);
    chk("c1_elapsed", 64'(elapsed_ms_out), 64'd1100);

    // CLOCK black, 3000/30 through the divider; white fields ignored
    push(EV_RUN, 32'd100, 34, 1'b0);
    push(EV_STOP, 32'd0, 1000, 1'b0);
    do_go(2'd0, 1'b1, 32'd999999, 32'd3000, 32'd777, 32'd0, 8'd30, 32'd0);
    wait_drain(1200, "clock_mtg");

    // cap: 25 - 20 = 5 beats 3 + 500
    push(EV_RUN, 32'd5, 2, 1'b0);
    push(EV_STOP, 32'd0, 50, 1'b0);
    do_go(2'd0, 1'b0, 32'd25, 32'd0, 32'd500, 32'd0, 8'd0, 32'd0);
    wait_drain(100, "cap");

    // negative clock and inc -> floor at 1 ms
    push(EV_RUN, 32'd1, 2, 1'b0);
    push(EV_STOP, 32'd0, 10, 1'b0);
    do_go(2'd0, 1'b0, 32'hFFFF_FFD8, 32'd0, 32'hFFFF_FFF9, 32'd0, 8'd0, 32'd0);
    wait_drain(50, "negative");

    // PONDER: budget 1000 held, then ponderhit starts the countdown
    do_go(2'd3, 1'b0, 32'd8000, 32'd0, 32'd0, 32'd0, 8'd0, 32'd999);
    repeat (2) @(posedge clk_in); #1;
    chk("hold_time0", 64'(time_ms_out), 64'd1000);
    chk("hold_busy", 64'(busy_out), 64'd1);
    repeat (500) @(posedge clk_in); #1;
    chk("hold_time500", 64'(time_ms_out), 64'd1000);
    chk("hold_elapsed500", 64'(elapsed_ms_out), 64'd0);
    push(EV_RUN, 32'd1000, 0, 1'b1);
    push(EV_STOP, 32'd0, 10000, 1'b1);
    pulse_ph();
    wait_drain(10100, "ponder");

    // INFINITE: elapsed counts, never stops by itself
    do_go(2'd2, 1'b0, 32'd8000, 32'd0, 32'd0, 32'd0, 8'd0, 32'd0);
    repeat (20002) @(posedge clk_in); #1;
    chk("inf_elapsed", 64'(elapsed_ms_out), 64'd2000);
    chk("inf_time", 64'(time_ms_out), 64'hFFFF_FFFF);
    chk("inf_running", 64'(running_out), 64'd0);
    chk("inf_busy", 64'(busy_out), 64'd1);
    push(EV_STOP, 32'd0, 0, 1'b1);  // pulse in the cycle after the sampling edge
    pulse_stop();
    wait_drain(5, "inf_stop");
    chk("inf_busy_after", 64'(busy_out), 64'd0);

    // MOVETIME 50 aborted at 200 cycles by MOVETIME 5
    push(EV_RUN, 32'd50, 2, 1'b0);
    do_go(2'd1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 8'd0, 32'd50);
    repeat (199) @(posedge clk_in); #1;
    push(EV_RUN, 32'd5, 2, 1'b0);
    push(EV_STOP, 32'd0, 50, 1'b0);
    do_go(2'd1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 8'd0, 32'd5);
    wait_drain(200, "restart");
    repeat (400) @(posedge clk_in); #1;

    // reset mid-RUN: everything clears, no stop pulse
    push(EV_RUN, 32'd1100, 2, 1'b0);
    do_go(2'd0, 1'b0, 32'd8000, 32'd0, 32'd100, 32'd0, 8'd0, 32'd0);
    repeat (300) @(posedge clk_in); #2;
    rst_n_in = 1'b0;
    #1;
    chk_zero("midrun_reset");
    @(negedge clk_in); #1;
    rst_n_in = 1'b1;
    repeat (30) @(posedge clk_in); #1;
    chk("final_queue", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
